wb_retire_buffer: RTL and testbench

- Parametrised writeback stage for the 5-stage MIPS pipeline, placed between MEM and the register file / HI-LO unit.
- Replaces the single stall-controlled WB register with a DEPTH-entry in-order retire FIFO using a valid/ready handshake.
- Supports byte-enable GPR writes, HI/LO writes and NUM_RD forwarding lookup ports with youngest-match priority.
- Provides a retire hold input, per-cycle debug trace and a retired-instruction counter.

---
 rtl/wb_retire_buffer_pkg.sv | 43 ++++
 rtl/wb_retire_buffer_lookup.sv | 42 ++++
 rtl/wb_retire_buffer.sv | 191 +++++++++++++++++++
 tb/tb_wb_retire_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_buffer_pkg.sv
// Shared field layout for retire-buffer entries.
package wb_retire_buffer_pkg;

  localparam int unsigned PC_W = 32;

  // Entry fields, listed from the least significant end of the packed entry.
  typedef enum logic [3:0] {
    F_LO,
    F_HI,
    F_LO_WE,
    F_HI_WE,
    F_WDATA,
    F_WADDR,
    F_WE,
    F_PC,
    F_END
  } wb_field_e;

  // Bit offset of a field inside a packed entry; F_END yields the entry width.
  function automatic int unsigned wb_off(wb_field_e f, int unsigned data_w, int unsigned addr_w);
    int unsigned be_w;
    int unsigned off;
    be_w = data_w / 8;
    case (f)
      F_LO:    off = 0;
      F_HI:    off = data_w;
      F_LO_WE: off = 2 * data_w;
      F_HI_WE: off = 2 * data_w + 1;
      F_WDATA: off = 2 * data_w + 2;
      F_WADDR: off = 3 * data_w + 2;
      F_WE:    off = 3 * data_w + 2 + addr_w;
      F_PC:    off = 3 * data_w + 2 + addr_w + be_w;
      default: off = 3 * data_w + 2 + addr_w + be_w + PC_W;
    endcase
    return off;
  endfunction

  // WB_ENTRY_W = 32 + BE_W + ADDR_W + DATA_W + 2 + 2*DATA_W
  function automatic int unsigned wb_entry_w(int unsigned data_w, int unsigned addr_w);
    return wb_off(F_END, data_w, addr_w);
  endfunction

endpackage

// File: rtl/wb_retire_buffer_lookup.sv
// Youngest-match priority scan over the buffered entries for one lookup key.
module wb_fwd_lookup #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [PTR_W-1:0]        head,
  input  logic [DEPTH*BE_W-1:0]   key_en,
  input  logic [DEPTH*ADDR_W-1:0] key_addr,
  input  logic [DEPTH*DATA_W-1:0] key_data,
  input  logic [ADDR_W-1:0]       raddr,
  output logic                    hit,
  output logic                    pending,
  output logic [DATA_W-1:0]       data
);

  logic [PTR_W-1:0] idx;
  logic [BE_W-1:0]  en;

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    hit     = 1'b0;
    pending = 1'b0;
    data    = '0;
    idx     = '0;
    en      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      en  = key_en[32'(idx)*BE_W +: BE_W];
      if (valid[idx] && (en != '0) && (raddr != '0) &&
          (key_addr[32'(idx)*ADDR_W +: ADDR_W] == raddr)) begin
        hit     = (en == '1);
        pending = (en != '1);
        data    = (en == '1) ? key_data[32'(idx)*DATA_W +: DATA_W] : '0;
      end
    end
  end

endmodule

// File: rtl/wb_retire_buffer.sv
// In-order writeback retire FIFO with GPR/HI/LO forwarding and debug trace.
module wb_retire_buffer
  import wb_retire_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [BE_W-1:0]          in_rf_we,
  input  logic [ADDR_W-1:0]        in_rf_waddr,
  input  logic [DATA_W-1:0]        in_rf_wdata,
  input  logic                     in_hi_we,
  input  logic                     in_lo_we,
  input  logic [DATA_W-1:0]        in_hi,
  input  logic [DATA_W-1:0]        in_lo,
  input  logic                     hold,
  output logic [BE_W-1:0]          rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     hi_we,
  output logic                     lo_we,
  output logic [DATA_W-1:0]        hi_o,
  output logic [DATA_W-1:0]        lo_o,
  input  logic [NUM_RD*ADDR_W-1:0] fwd_raddr,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD-1:0]        fwd_pending,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic                     fwd_hi_valid,
  output logic                     fwd_lo_valid,
  output logic [DATA_W-1:0]        fwd_hi,
  output logic [DATA_W-1:0]        fwd_lo,
  output logic [31:0]              debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [31:0]              debug_wb_rf_wdata,
  output logic [31:0]              retired_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = wb_entry_w(DATA_W, ADDR_W);
  localparam int unsigned O_LO    = wb_off(F_LO, DATA_W, ADDR_W);
  localparam int unsigned O_HI    = wb_off(F_HI, DATA_W, ADDR_W);
  localparam int unsigned O_LO_WE = wb_off(F_LO_WE, DATA_W, ADDR_W);
  localparam int unsigned O_HI_WE = wb_off(F_HI_WE, DATA_W, ADDR_W);
  localparam int unsigned O_WDATA = wb_off(F_WDATA, DATA_W, ADDR_W);
  localparam int unsigned O_WADDR = wb_off(F_WADDR, DATA_W, ADDR_W);
  localparam int unsigned O_WE    = wb_off(F_WE, DATA_W, ADDR_W);
  localparam int unsigned O_PC    = wb_off(F_PC, DATA_W, ADDR_W);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   age;
  logic [PTR_W:0]     count;
  logic [DEPTH-1:0]   valid;
  logic               accept;
  logic               retire;

  assign in_entry   = {in_pc, in_rf_we, in_rf_waddr, in_rf_wdata, in_hi_we, in_lo_we, in_hi, in_lo};
  assign head_entry = mem[head];

  assign in_ready = (count != (PTR_W + 1)'(DEPTH));
  assign accept   = in_valid & in_ready;
  // rst gates retirement so no write strobe leaks out while discarding entries.
  assign retire   = (count != '0) & ~hold & ~rst;

  assign rf_we             = retire ? head_entry[O_WE +: BE_W] : '0;
  assign rf_waddr          = retire ? head_entry[O_WADDR +: ADDR_W] : '0;
  assign rf_wdata          = retire ? head_entry[O_WDATA +: DATA_W] : '0;
  assign hi_we             = retire & head_entry[O_HI_WE];
  assign lo_we             = retire & head_entry[O_LO_WE];
  assign hi_o              = retire ? head_entry[O_HI +: DATA_W] : '0;
  assign lo_o              = retire ? head_entry[O_LO +: DATA_W] : '0;
  assign debug_wb_pc       = retire ? head_entry[O_PC +: 32] : '0;
  assign debug_wb_rf_wen   = 4'(rf_we);
  assign debug_wb_rf_wnum  = 5'(rf_waddr);
  assign debug_wb_rf_wdata = 32'(rf_wdata);

  // Pointer, occupancy and retire-count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      retired_cnt <= '0;
    end else begin
      if (accept) tail <= tail + PTR_W'(1);
      if (retire) begin
        head        <= head + PTR_W'(1);
        retired_cnt <= retired_cnt + 32'd1;
      end
      case ({accept, retire})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under the valid mask.
  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= in_entry;
  end

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(i) - head;
      valid[i] = ({1'b0, age} < count);
    end
  end

  logic [DEPTH*BE_W-1:0]   gpr_en;
  logic [DEPTH*BE_W-1:0]   hi_en;
  logic [DEPTH*BE_W-1:0]   lo_en;
  logic [DEPTH*ADDR_W-1:0] gpr_addr;
  logic [DEPTH*ADDR_W-1:0] any_addr;
  logic [DEPTH*DATA_W-1:0] gpr_data;
  logic [DEPTH*DATA_W-1:0] hi_data;
  logic [DEPTH*DATA_W-1:0] lo_data;
  logic                    hi_hit;
  logic                    hi_pend;
  logic                    lo_hit;
  logic                    lo_pend;

  // HI/LO reuse the GPR scan: a full-width enable and a fixed nonzero key always match.
  assign any_addr = '1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_keys
    assign gpr_en[i*BE_W +: BE_W]       = mem[i][O_WE +: BE_W];
    assign gpr_addr[i*ADDR_W +: ADDR_W] = mem[i][O_WADDR +: ADDR_W];
    assign gpr_data[i*DATA_W +: DATA_W] = mem[i][O_WDATA +: DATA_W];
    assign hi_en[i*BE_W +: BE_W]        = {BE_W{mem[i][O_HI_WE]}};
    assign lo_en[i*BE_W +: BE_W]        = {BE_W{mem[i][O_LO_WE]}};
    assign hi_data[i*DATA_W +: DATA_W]  = mem[i][O_HI +: DATA_W];
    assign lo_data[i*DATA_W +: DATA_W]  = mem[i][O_LO +: DATA_W];
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_fwd
    wb_fwd_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) u_lookup (
      .valid    (valid),
      .head     (head),
      .key_en   (gpr_en),
      .key_addr (gpr_addr),
      .key_data (gpr_data),
      .raddr    (fwd_raddr[r*ADDR_W +: ADDR_W]),
      .hit      (fwd_hit[r]),
      .pending  (fwd_pending[r]),
      .data     (fwd_data[r*DATA_W +: DATA_W])
    );
  end

  wb_fwd_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) u_hi_lookup (
    .valid    (valid),
    .head     (head),
    .key_en   (hi_en),
    .key_addr (any_addr),
    .key_data (hi_data),
    .raddr    (any_addr[ADDR_W-1:0]),
    .hit      (hi_hit),
    .pending  (hi_pend),
    .data     (fwd_hi)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) u_lo_lookup (
    .valid    (valid),
    .head     (head),
    .key_en   (lo_en),
    .key_addr (any_addr),
    .key_data (lo_data),
    .raddr    (any_addr[ADDR_W-1:0]),
    .hit      (lo_hit),
    .pending  (lo_pend),
    .data     (fwd_lo)
  );

  assign fwd_hi_valid = hi_hit | hi_pend;
  assign fwd_lo_valid = lo_hit | lo_pend;

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Self-checking bench for wb_retire_buffer against a queue-based reference model.
module tb_wb_retire_buffer;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned NUM_RD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [31:0] in_rf_wdata;
  logic        in_hi_we, in_lo_we;
  logic [31:0] in_hi, in_lo;
  logic        hold;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic [9:0]  fwd_raddr;
  logic [1:0]  fwd_hit, fwd_pending;
  logic [63:0] fwd_data;
  logic        fwd_hi_valid, fwd_lo_valid;
  logic [31:0] fwd_hi, fwd_lo;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  wb_retire_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
    .in_hi_we(in_hi_we), .in_lo_we(in_lo_we), .in_hi(in_hi), .in_lo(in_lo), .hold(hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_we(hi_we), .lo_we(lo_we),
    .hi_o(hi_o), .lo_o(lo_o), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit),
    .fwd_pending(fwd_pending), .fwd_data(fwd_data), .fwd_hi_valid(fwd_hi_valid),
    .fwd_lo_valid(fwd_lo_valid), .fwd_hi(fwd_hi), .fwd_lo(fwd_lo),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t        q[$];
  logic [31:0] cnt_model = '0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] we,
                       input logic [4:0] a, input logic [31:0] d, input logic hw,
                       input logic [31:0] h, input logic lw, input logic [31:0] l);
    in_valid = v; in_pc = pc; in_rf_we = we; in_rf_waddr = a; in_rf_wdata = d;
    in_hi_we = hw; in_hi = h; in_lo_we = lw; in_lo = l;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Reference: youngest queued entry writing this register decides hit/pending.
  task automatic ref_fwd(input logic [4:0] ra, output bit h, output bit p, output logic [31:0] d);
    h = 0; p = 0; d = '0;
    if (ra != 0) begin
      for (int j = int'(q.size()) - 1; j >= 0; j--) begin
        if (q[j].we != 0 && q[j].addr == ra) begin
          h = (q[j].we == 4'hF);
          p = !h;
          d = h ? q[j].data : '0;
          break;
        end
      end
    end
  endtask

  task automatic ref_hl(input bit sel_hi, output bit v, output logic [31:0] d);
    v = 0; d = '0;
    for (int j = int'(q.size()) - 1; j >= 0; j--) begin
      if (sel_hi ? q[j].hi_we : q[j].lo_we) begin
        v = 1; d = sel_hi ? q[j].hi : q[j].lo;
        break;
      end
    end
  endtask

  // Check every output against the model, then take one clock edge and update the model.
  task automatic step();
    bit          rdy, ret, h, p, v;
    logic [31:0] d;
    ent_t        e, cur;
    #1;
    rdy = (q.size() != DEPTH);
    ret = (q.size() != 0) && !hold && !rst;
    e = '{pc: '0, we: '0, addr: '0, data: '0, hi_we: 1'b0, lo_we: 1'b0, hi: '0, lo: '0};
    if (ret) e = q[0];
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("rf_we", 64'(rf_we), 64'(e.we));
    chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
    chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
    chk("hi_we", 64'(hi_we), 64'(e.hi_we));
    chk("lo_we", 64'(lo_we), 64'(e.lo_we));
    chk("hi_o", 64'(hi_o), 64'(e.hi));
    chk("lo_o", 64'(lo_o), 64'(e.lo));
    chk("debug_pc", 64'(debug_wb_pc), 64'(e.pc));
    chk("debug_wen", 64'(debug_wb_rf_wen), 64'(e.we));
    chk("debug_wnum", 64'(debug_wb_rf_wnum), 64'(e.addr));
    chk("debug_wdata", 64'(debug_wb_rf_wdata), 64'(e.data));
    chk("retired_cnt", 64'(retired_cnt), 64'(cnt_model));
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      ref_fwd(fwd_raddr[r*5 +: 5], h, p, d);
      chk($sformatf("fwd_hit%0d", r), 64'(fwd_hit[r]), 64'(h));
      chk($sformatf("fwd_pending%0d", r), 64'(fwd_pending[r]), 64'(p));
      if (!p) chk($sformatf("fwd_data%0d", r), 64'(fwd_data[r*32 +: 32]), 64'(d));
    end
    ref_hl(1'b1, v, d);
    chk("fwd_hi_valid", 64'(fwd_hi_valid), 64'(v));
    chk("fwd_hi", 64'(fwd_hi), 64'(d));
    ref_hl(1'b0, v, d);
    chk("fwd_lo_valid", 64'(fwd_lo_valid), 64'(v));
    chk("fwd_lo", 64'(fwd_lo), 64'(d));
    last_acc = in_valid && rdy && !rst;
    cur = '{pc: in_pc, we: in_rf_we, addr: in_rf_waddr, data: in_rf_wdata,
            hi_we: in_hi_we, lo_we: in_lo_we, hi: in_hi, lo: in_lo};
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt_model = '0;
    end else begin
      if (ret) begin
        void'(q.pop_front());
        cnt_model = cnt_model + 32'd1;
      end
      if (last_acc) q.push_back(cur);
    end
    @(negedge clk);
  endtask

  // Present the current bundle until the model says it was taken (bounded).
  task automatic push_until_taken();
    int unsigned guard = 0;
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 8);
    idle();
  endtask

  logic [3:0] wep;

  initial begin
    rst = 1'b1; hold = 1'b0; fwd_raddr = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    step();

    // Single full-word write, retires the following cycle
    drive(1'b1, 32'hBFC0_0000, 4'hF, 5'd3, 32'h1234_5678, 1'b0, '0, 1'b0, '0);
    fwd_raddr = {5'd0, 5'd3};
    step();
    idle();
    step();
    step();

    // Fill and backpressure with hold, then in-order drain
    hold = 1'b1;
    drive(1'b1, 32'h100, 4'hF, 5'd1, 32'h11, 1'b0, '0, 1'b0, '0); step();
    drive(1'b1, 32'h104, 4'hF, 5'd2, 32'h22, 1'b0, '0, 1'b0, '0); step();
    drive(1'b1, 32'h108, 4'hF, 5'd3, 32'h33, 1'b0, '0, 1'b0, '0); step();
    step();
    hold = 1'b0;
    push_until_taken();
    repeat (3) step();

    // Youngest match wins; address 0 never matches
    hold = 1'b1;
    fwd_raddr = {5'd0, 5'd5};
    drive(1'b1, 32'h200, 4'hF, 5'd5, 32'hA, 1'b0, '0, 1'b0, '0); step();
    drive(1'b1, 32'h204, 4'hF, 5'd5, 32'hB, 1'b0, '0, 1'b0, '0); step();
    idle(); step();
    hold = 1'b0;
    repeat (3) step();

    // Partial write pends forwarding until it retires
    hold = 1'b1;
    fwd_raddr = {5'd7, 5'd7};
    drive(1'b1, 32'h300, 4'h3, 5'd7, 32'hCAFE, 1'b0, '0, 1'b0, '0); step();
    idle(); step();
    hold = 1'b0;
    repeat (2) step();

    // HI write forwarded then retired; LO untouched
    hold = 1'b1;
    drive(1'b1, 32'h400, 4'h0, 5'd0, '0, 1'b1, 32'hDEAD, 1'b0, 32'h5555); step();
    idle(); step();
    hold = 1'b0;
    repeat (2) step();

    // Reset with two entries buffered: no strobe, everything discarded
    hold = 1'b1;
    fwd_raddr = {5'd9, 5'd8};
    drive(1'b1, 32'h500, 4'hF, 5'd8, 32'h88, 1'b1, 32'h1, 1'b1, 32'h2); step();
    drive(1'b1, 32'h504, 4'hF, 5'd9, 32'h99, 1'b0, '0, 1'b0, '0); step();
    idle();
    hold = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; step();
    step();

    // Randomized traffic with occasional hold and reset
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: wep = 4'h0;
        1: wep = 4'hF;
        2: wep = 4'h3;
        3: wep = 4'hC;
        4: wep = 4'hF;
        default: wep = 4'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom, wep, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom);
      hold = ($urandom_range(0, 3) == 0);
      rst  = ((n % 97) == 50);
      fwd_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end
    rst = 1'b0; hold = 1'b0; idle();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
